// File: rtl/table_stream_pkg.sv
// table_stream_pkg: shared FSM states, buffer depth and index wrap helper for the table read streamer
package table_stream_pkg;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

   localparam int BUF_DEPTH = 2;

   function automatic int unsigned idx_wrap(input int unsigned base, input int unsigned offset,
                                            input int unsigned size);
      return (base + offset) % size;
   endfunction

endpackage

// File: rtl/table_rd_skid_buf.sv
// table_rd_skid_buf: 2-entry FIFO absorbing read data in flight while the consumer stalls
module table_rd_skid_buf
   import table_stream_pkg::*;
#(
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   occ
);

   logic [W-1:0] mem [BUF_DEPTH];
   logic         wp;
   logic         rp;

   assign dout = mem[rp];

   // storage, pointers and occupancy; caller guarantees no push when full or pop when empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
         wp  <= 1'b0;
         rp  <= 1'b0;
         occ <= 2'd0;
      end else begin
         if (push) mem[wp] <= din;
         wp  <= wp ^ push;
         rp  <= rp ^ pop;
         occ <= occ + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: rtl/table_rd_streamer.sv
// table_rd_streamer: walks a window of table entries and streams them as valid/ready beats; define TABLE_RD_STREAM_CHECKSUM_EN for the checksum port
module table_rd_streamer
   import table_stream_pkg::*;
#(
   parameter  int TABLE_SIZE  = 32,
   parameter  int DATA_WIDTH  = 8,
   parameter  int OUTPUT_RATE = 2,
   localparam int IW          = $clog2(TABLE_SIZE)
)(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [IW-1:0]                     start_index,
   input  logic [IW:0]                       beat_count,
   output logic                              busy,
   output logic                              done,
   output logic                              rd_en,
   output logic [OUTPUT_RATE*IW-1:0]         index_rd,
   input  logic [OUTPUT_RATE*DATA_WIDTH-1:0] data_rd,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [OUTPUT_RATE*DATA_WIDTH-1:0] out_data,
   output logic [IW-1:0]                     out_index,
   output logic                              out_last
`ifdef TABLE_RD_STREAM_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0]             checksum
`endif
);

   localparam int BW = OUTPUT_RATE*DATA_WIDTH + IW + 1;

   state_t          state;
   state_t          nxt;
   logic [IW:0]     reads_left;
   logic            last_rd;
   logic            inflight;
   logic            infl_last;
   logic [IW-1:0]   infl_idx;
   logic            pop;
   logic            credit_ok;
   logic            job_start;
   logic [1:0]      occ;
   logic [BW-1:0]   head;

   assign job_start = state == IDLE && start;
   assign last_rd   = reads_left == (IW+1)'(1);
   assign out_valid = occ != 2'd0;
   assign pop       = out_valid && out_ready;
   assign {out_data, out_index, out_last} = head;
   assign credit_ok = 3'(occ) + 3'(inflight) - 3'(pop) < 3'd2;

   table_rd_skid_buf #(.W(BW)) u_buf (
      .clk  (clk),
      .rst  (rst),
      .push (inflight),
      .pop  (pop),
      .din  ({data_rd, infl_idx, infl_last}),
      .dout (head),
      .occ  (occ)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // next state: empty jobs skip straight to FINISH
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? (beat_count == '0 ? FINISH : READ) : IDLE;
         READ:    nxt = rd_en && last_rd ? DRAIN : READ;
         DRAIN:   nxt = pop && out_last ? FINISH : DRAIN;
         default: nxt = IDLE;
      endcase
   end

   // outputs: a read goes out only when its data is sure to find room in the buffer
   always_comb begin
      busy  = state != IDLE;
      done  = state == FINISH;
      rd_en = state == READ && credit_ok;
   end

   // read pointer, remaining reads and the tag of the read whose data lands next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         index_rd   <= '0;
         reads_left <= '0;
         inflight   <= 1'b0;
         infl_last  <= 1'b0;
         infl_idx   <= '0;
      end else begin
         inflight <= rd_en;
         if (job_start) begin
            reads_left <= beat_count;
            for (int j = 0; j < OUTPUT_RATE; j++)
               index_rd[j*IW +: IW] <= IW'(idx_wrap(32'(start_index), j, TABLE_SIZE));
         end
         if (rd_en) begin
            reads_left <= reads_left - 1'b1;
            infl_idx   <= index_rd[IW-1:0];
            infl_last  <= last_rd;
            for (int j = 0; j < OUTPUT_RATE; j++)
               index_rd[j*IW +: IW] <= IW'(idx_wrap(32'(index_rd[IW-1:0]), OUTPUT_RATE + j, TABLE_SIZE));
         end
      end
   end

`ifdef TABLE_RD_STREAM_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] lane_xor;

   // fold all lanes of the beat on the output
   always_comb begin
      lane_xor = '0;
      for (int j = 0; j < OUTPUT_RATE; j++) lane_xor = lane_xor ^ out_data[j*DATA_WIDTH +: DATA_WIDTH];
   end

   // running checksum of handshaken beats, restarted by each accepted job
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            checksum <= '0;
      else if (job_start) checksum <= '0;
      else if (pop)       checksum <= checksum ^ lane_xor;
   end
`endif

endmodule
